// File: rtl/mult8_nibble_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mult8_nibble_sequencer
// Description : Computes 8x8 -> 16-bit unsigned products in four passes through
//               one shared, external, combinational 4x4 multiplier. Operands are
//               latched on a valid/ready handshake. One nibble pair is presented
//               to the multiplier per cycle, and the shifted partial products are
//               accumulated. The result is offered on a valid/ready output port.
// Ports       : clk        - system clock, rising edge
//               rst_n      - synchronous reset, active low
//               in_valid   - operand pair valid
//               in_ready   - block can accept operands (IDLE, out of reset)
//               in_a, in_b - unsigned operands
//               mul_a      - nibble to shared multiplier operand m
//               mul_b      - nibble to shared multiplier operand q
//               mul_p      - same-cycle product from the shared multiplier
//               out_valid  - out_p holds a finished product
//               out_ready  - consumer takes out_p
//               out_p      - product in_a*in_b
//               busy       - high while multiplying or holding a result
// Parameters  : NIBW must be 4 and OPW must equal 2*NIBW; other values are
//               not supported.
// Revision    : 1.0 - initial release
// ============================================================================
module mult8_nibble_sequencer #(
  parameter int NIBW = 4,
  parameter int OPW  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPW-1:0]    in_a,
  input  logic [OPW-1:0]    in_b,
  output logic [NIBW-1:0]   mul_a,
  output logic [NIBW-1:0]   mul_b,
  input  logic [2*NIBW-1:0] mul_p,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*OPW-1:0]  out_p,
  output logic              busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       step;
  logic [2*OPW-1:0] acc;
  logic [OPW-1:0]   a_q;
  logic [OPW-1:0]   b_q;
  logic [2*OPW-1:0] out_p_q;

  logic [2*OPW-1:0] pp_ext;
  logic [2*OPW-1:0] pp_shifted;
  logic [2*OPW-1:0] acc_next;

  // in_ready is gated with rst_n so that nothing is advertised while the
  // block is held in reset. A reset edge would discard an accept anyway.
  assign in_ready  = (state == S_IDLE) && rst_n;
  assign out_valid = (state == S_DONE);
  assign busy      = (state == S_MUL) || (state == S_DONE);
  assign out_p     = out_p_q;

  // The nibble selection and the partial-product weight both follow the step.
  // Steps 1 and 2 carry the same weight (cross terms).
  always_comb begin
    mul_a      = '0;
    mul_b      = '0;
    pp_ext     = {{OPW{1'b0}}, mul_p};
    pp_shifted = '0;
    if (state == S_MUL) begin
      case (step)
        2'd0: begin
          mul_a      = a_q[NIBW-1:0];
          mul_b      = b_q[NIBW-1:0];
          pp_shifted = pp_ext;
        end
        2'd1: begin
          mul_a      = a_q[OPW-1:NIBW];
          mul_b      = b_q[NIBW-1:0];
          pp_shifted = pp_ext << NIBW;
        end
        2'd2: begin
          mul_a      = a_q[NIBW-1:0];
          mul_b      = b_q[OPW-1:NIBW];
          pp_shifted = pp_ext << NIBW;
        end
        default: begin
          mul_a      = a_q[OPW-1:NIBW];
          mul_b      = b_q[OPW-1:NIBW];
          pp_shifted = pp_ext << OPW;
        end
      endcase
    end
  end

  // The largest possible sum is 0xFE01, so the 16-bit add cannot wrap.
  assign acc_next = acc + pp_shifted;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      step    <= 2'd0;
      acc     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      out_p_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_q   <= in_a;
            b_q   <= in_b;
            acc   <= '0;
            step  <= 2'd0;
            state <= S_MUL;
          end
        end
        S_MUL: begin
          acc  <= acc_next;
          step <= step + 2'd1;
          if (step == 2'd3) begin
            out_p_q <= acc_next;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult8_nibble_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult8_nibble_sequencer
// Description : Self-checking bench for mult8_nibble_sequencer. It models the
//               external 4x4 multiplier and keeps a scoreboard queue of
//               expected products.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult8_nibble_sequencer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic [3:0]  mul_a;
  logic [3:0]  mul_b;
  logic [7:0]  mul_p;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_p;
  logic        busy;

  int          checks;
  int          errors;
  logic [15:0] exp_q[$];

  mult8_nibble_sequencer #(.NIBW(4), .OPW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .busy      (busy)
  );

  // Model of the external combinational 4x4 multiplier
  assign mul_p = {4'b0, mul_a} * {4'b0, mul_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] exp_nib_a(input logic [7:0] a, input int s);
    return (s == 1 || s == 3) ? a[7:4] : a[3:0];
  endfunction

  function automatic logic [3:0] exp_nib_b(input logic [7:0] b, input int s);
    return (s >= 2) ? b[7:4] : b[3:0];
  endfunction

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_a = 8'h00; in_b = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0)   begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_p !== 16'h0000)  begin errors++; $display("FAIL reset_out_p got %h want 0000", out_p); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if ({mul_a, mul_b} !== 8'h00) begin errors++; $display("FAIL reset_mul got %h/%h want 0/0", mul_a, mul_b); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL reset_release_in_ready got %b want 1", in_ready); end
  endtask

  // Accept 0x12*0x34, follow the nibble sequence, check latency and result.
  task automatic test_single;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] e;
    a = 8'h12; b = 8'h34;
    in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready got %b want 1", in_ready); end
    exp_q.push_back(16'(a) * 16'(b));
    @(negedge clk);
    in_valid = 1'b0;
    for (int s = 0; s < 4; s++) begin
      checks++;
      if (mul_a !== exp_nib_a(a, s) || mul_b !== exp_nib_b(b, s)) begin
        errors++;
        $display("FAIL single_step%0d_nibbles got %h/%h want %h/%h", s, mul_a, mul_b, exp_nib_a(a, s), exp_nib_b(b, s));
      end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_step%0d_early_valid got %b want 0", s, out_valid); end
      @(negedge clk);
    end
    e = exp_q.pop_front();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_latency_valid got %b want 1", out_valid); end
    checks++; if (out_p !== e)        begin errors++; $display("FAIL single_out_p got %h want %h", out_p, e); end
    checks++; if (out_p !== 16'h03A8) begin errors++; $display("FAIL single_out_p_const got %h want 03a8", out_p); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL single_handshake got valid=%b ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  // Boundary operands: all ones, zero on either side, single high bits.
  task automatic test_corners;
    logic [15:0] pairs[5];
    logic [15:0] e;
    pairs[0] = 16'hFFFF; pairs[1] = 16'h00AB; pairs[2] = 16'hAB00;
    pairs[3] = 16'h8080; pairs[4] = 16'h0F10;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_a = pairs[i][15:8]; in_b = pairs[i][7:0]; in_valid = 1'b1;
      exp_q.push_back(16'(pairs[i][15:8]) * 16'(pairs[i][7:0]));
      @(negedge clk);
      in_valid = 1'b0;
      for (int k = 0; k < 10 && !out_valid; k++) @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL corner%0d_timeout got valid=%b want 1", i, out_valid); end
      else if (out_p !== e)   begin errors++; $display("FAIL corner%0d_out_p got %h want %h", i, out_p, e); end
      @(negedge clk);
    end
    checks++; if (out_p !== 16'h00F0) begin errors++; $display("FAIL corner_0f_10 got %h want 00f0", out_p); end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    logic [15:0] e;
    out_ready = 1'b0;
    in_a = 8'hA5; in_b = 8'h3C; in_valid = 1'b1;
    exp_q.push_back(16'(8'hA5) * 16'(8'h3C));
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 10 && !out_valid; k++) @(negedge clk);
    e = exp_q.pop_front();
    checks++; if (out_valid !== 1'b1 || out_p !== e) begin
      errors++; $display("FAIL bp_first got valid=%b p=%h want 1/%h", out_valid, out_p, e);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_p !== e || in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold%0d got valid=%b p=%h ready=%b busy=%b want 1/%h/0/1", k, out_valid, out_p, in_ready, busy, e);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release got valid=%b ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] e;
    out_ready = 1'b1;
    in_a = 8'h77; in_b = 8'h9C; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (mul_a !== 4'h7 || mul_b !== 4'h9) begin
      errors++; $display("FAIL rmid_step2 got %h/%h want 7/9", mul_a, mul_b);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || {mul_a, mul_b} !== 8'h00) begin
      errors++; $display("FAIL rmid_abort got valid=%b busy=%b ready=%b mul=%h%h want 0/0/0/00", out_valid, busy, in_ready, mul_a, mul_b);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rmid_idle got ready=%b valid=%b want 1/0", in_ready, out_valid);
    end
    in_a = 8'h0F; in_b = 8'h10; in_valid = 1'b1;
    exp_q.push_back(16'h00F0);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 10 && !out_valid; k++) @(negedge clk);
    e = exp_q.pop_front();
    checks++; if (out_valid !== 1'b1 || out_p !== e) begin
      errors++; $display("FAIL rmid_next got valid=%b p=%h want 1/%h", out_valid, out_p, e);
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // Scramble the operand inputs every cycle while the multiply runs.
  task automatic test_toggle;
    logic [15:0] e;
    out_ready = 1'b0;
    in_a = 8'hC7; in_b = 8'h5E; in_valid = 1'b1;
    exp_q.push_back(16'(8'hC7) * 16'(8'h5E));
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 10 && !out_valid; k++) begin
      in_a = ~in_a ^ 8'(k); in_b = in_b + 8'h33;
      @(negedge clk);
    end
    e = exp_q.pop_front();
    checks++; if (out_valid !== 1'b1 || out_p !== e) begin
      errors++; $display("FAIL toggle_result got valid=%b p=%h want 1/%h", out_valid, out_p, e);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    int   pushed;
    int   got;
    int   cyc;
    int   last_cyc;
    bit   accepted_last;
    logic [15:0] e;
    pushed = 0; got = 0; cyc = 0; last_cyc = -1; accepted_last = 1'b0;
    out_ready = 1'b1;
    in_a = 8'($urandom); in_b = 8'($urandom); in_valid = 1'b1;
    while (got < 20 && cyc < 200) begin
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_extra_result got %h want none", out_p);
        end else begin
          e = exp_q.pop_front();
          if (out_p !== e) begin errors++; $display("FAIL b2b_result%0d got %h want %h", got, out_p, e); end
        end
        if (last_cyc >= 0) begin
          checks++;
          if (cyc - last_cyc != 6) begin errors++; $display("FAIL b2b_spacing%0d got %0d want 6", got, cyc - last_cyc); end
        end
        last_cyc = cyc;
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(16'(in_a) * 16'(in_b));
        pushed++;
        accepted_last = 1'b1;
      end else if (accepted_last) begin
        accepted_last = 1'b0;
        in_a = 8'($urandom); in_b = 8'($urandom);
        if (pushed == 20) in_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    checks++; if (got != 20 || pushed != 20 || exp_q.size() != 0) begin
      errors++; $display("FAIL b2b_count got results=%0d pushed=%0d left=%0d want 20/20/0", got, pushed, exp_q.size());
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_corners();
    test_backpressure();
    test_reset_mid();
    test_toggle();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
